// File: rtl/register_file_4x8.sv
// ----------------------------------------------------------------------------
// register_file_4x8
//
// Four-entry, 8-bit general-purpose register file for the 8-bit CPU datapath.
// Two independent combinational read ports feed the ALU operand paths and one
// synchronous write port is driven by the writeback stage. Every register is
// ordinary writable storage (no hardwired zero register).
//
// Parameters:
//   DATA_WIDTH  width of each register and of the data ports (default 8)
//   ADDR_WIDTH  width of the address ports (default 2)
//   NUM_REGS    number of registers, must equal 2**ADDR_WIDTH (default 4)
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset, clears every register
//   rs1_addr   in   read port 1 address
//   rs2_addr   in   read port 2 address
//   wr_addr    in   write port address
//   wr_data    in   write data
//   reg_wr_en  in   write enable, active-high
//   rs1_data   out  contents of register[rs1_addr] (combinational)
//   rs2_data   out  contents of register[rs2_addr] (combinational)
// ----------------------------------------------------------------------------
module register_file_4x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    // NUM_REGS == 2**ADDR_WIDTH, so every address selects a real entry and
    // the read muxes need no out-of-range handling.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Reset takes priority: a write presented on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (reg_wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write-to-read bypass: reads see the stored value, so a register
    // being written shows its old contents until the edge.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
    end

endmodule

// File: tb/tb_register_file_4x8.sv
// ----------------------------------------------------------------------------
// tb_register_file_4x8
//
// Directed testbench for register_file_4x8. Inputs change on the falling
// edge; outputs are sampled 1 ns after the rising edge or mid-cycle.
// ----------------------------------------------------------------------------
module tb_register_file_4x8;

    logic       clk;
    logic       reset;
    logic [1:0] rs1_addr;
    logic [1:0] rs2_addr;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       reg_wr_en;
    logic [7:0] rs1_data;
    logic [7:0] rs2_data;

    int unsigned n_checks;
    int unsigned n_fails;

    logic [7:0] exp_regs [4];

    register_file_4x8 #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2),
        .NUM_REGS   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_wr_en (reg_wr_en),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_addr   = a;
        wr_data   = d;
        reg_wr_en = 1'b1;
        tick();
        reg_wr_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        // Reset with a write pending for two edges.
        reset     = 1'b1;
        reg_wr_en = 1'b1;
        wr_addr   = 2'd2;
        wr_data   = 8'hAA;
        rs1_addr  = 2'd0;
        rs2_addr  = 2'd1;
        tick();
        tick();
        check("rst_rs1_a0", rs1_data, 8'h00);
        check("rst_rs2_a1", rs2_data, 8'h00);
        rs1_addr = 2'd2;
        rs2_addr = 2'd3;
        #1;
        check("rst_r2_lost", rs1_data, 8'h00);
        check("rst_r3", rs2_data, 8'h00);

        // Release reset with the write still presented.
        @(negedge clk);
        reset = 1'b0;
        tick();
        reg_wr_en = 1'b0;
        check("wr_r2", rs1_data, 8'hAA);
        rs1_addr = 2'd0;
        rs2_addr = 2'd1;
        #1;
        check("wr_r0_untouched", rs1_data, 8'h00);
        check("wr_r1_untouched", rs2_data, 8'h00);

        // Write disabled: r2 must hold.
        @(negedge clk);
        wr_addr   = 2'd2;
        wr_data   = 8'h55;
        reg_wr_en = 1'b0;
        tick();
        tick();
        tick();
        rs1_addr = 2'd2;
        #1;
        check("wr_dis_r2", rs1_data, 8'hAA);

        // Back-to-back writes to r0: last one wins.
        @(negedge clk);
        wr_addr   = 2'd0;
        wr_data   = 8'h44;
        reg_wr_en = 1'b1;
        tick();
        @(negedge clk);
        wr_data = 8'h11;
        tick();
        reg_wr_en = 1'b0;
        rs1_addr  = 2'd0;
        #1;
        check("b2b_r0", rs1_data, 8'h11);

        // Fill remaining registers, then sweep both read ports.
        write_reg(2'd1, 8'h22);
        write_reg(2'd3, 8'hFF);
        exp_regs[0] = 8'h11;
        exp_regs[1] = 8'h22;
        exp_regs[2] = 8'hAA;
        exp_regs[3] = 8'hFF;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                rs1_addr = 2'(a);
                rs2_addr = 2'(b);
                #1;
                check($sformatf("sweep_rs1_%0d_%0d", a, b), rs1_data, exp_regs[a]);
                check($sformatf("sweep_rs2_%0d_%0d", a, b), rs2_data, exp_regs[b]);
            end
        end

        // Same-cycle read/write: old value before the edge, new after.
        @(negedge clk);
        rs1_addr  = 2'd1;
        wr_addr   = 2'd1;
        wr_data   = 8'h33;
        reg_wr_en = 1'b1;
        #1;
        check("rw_before_edge", rs1_data, 8'h22);
        tick();
        reg_wr_en = 1'b0;
        check("rw_after_edge", rs1_data, 8'h33);

        // Mid-operation reset with a write pending clears everything.
        @(negedge clk);
        reset     = 1'b1;
        reg_wr_en = 1'b1;
        wr_addr   = 2'd0;
        wr_data   = 8'h77;
        tick();
        @(negedge clk);
        reset     = 1'b0;
        reg_wr_en = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rs1_addr = 2'(a);
            rs2_addr = 2'(3 - a);
            #1;
            check($sformatf("midrst_rs1_%0d", a), rs1_data, 8'h00);
            check($sformatf("midrst_rs2_%0d", 3 - a), rs2_data, 8'h00);
        end

        // Writing resumes after reset release.
        write_reg(2'd3, 8'h5A);
        rs1_addr = 2'd3;
        #1;
        check("post_rst_wr_r3", rs1_data, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
